scroll_ctrl: RTL and testbench

- Upstream stage of the floor generator. Produces the `hit_ceiling` flag and the 9-bit `time_gap` schedule that drive floor scrolling.
- Detects when the player cube reaches the ceiling band while rising. It then runs a per-frame scroll timer from 1 to GAP_MAX and stops.
- Also accumulates the total scrolled pixel distance for the score/HUD logic. It uses the same step schedule the floor stage applies, so the count matches actual floor motion.

---
 rtl/scroll_ctrl.sv | 112 +++++++++++
 tb/tb_scroll_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scroll_ctrl.sv
// Ceiling-hit detector and per-frame scroll scheduler feeding the floor generator.
// Optional build macro SCROLL_RETRIGGER_EN lets a new ceiling hit restart a running episode.
module scroll_ctrl #(
  parameter logic [9:0] CEIL_Y  = 10'd40,
  parameter logic [8:0] GAP_MAX = 9'd320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       freeze,
  input  logic [9:0] player_y,
  input  logic       player_rising,
  output logic       hit_ceiling,
  output logic [8:0] time_gap,
  output logic [9:0] scroll_dist,
  output logic       scroll_start
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCROLL = 2'b01
  } state_t;

  state_t     state, state_nxt;
  logic       at_ceil, at_ceil_q, trigger, update, step, retrig;
  logic [8:0] gap_nxt;
  logic       hit_nxt, start_nxt;
  logic [9:0] dist_nxt;

  assign update  = frame_tick && !freeze;
  assign at_ceil = (player_y <= CEIL_Y) && player_rising;
  assign trigger = at_ceil && !at_ceil_q;

`ifdef SCROLL_RETRIGGER_EN
  assign retrig = 1'b1;
`else
  assign retrig = 1'b0;
`endif

  // Step schedule mirrors the floor stage: the scroll slows down in four bands of 80 frames.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    step = 1'b0;
    if (state == SCROLL) begin
      if (time_gap >= 9'd1 && time_gap < 9'd80)         step = 1'b1;
      else if (time_gap >= 9'd80  && time_gap < 9'd160) step = (time_gap[0]   == 1'b0);
      else if (time_gap >= 9'd160 && time_gap < 9'd240) step = (time_gap[1:0] == 2'b00);
      else if (time_gap >= 9'd240 && time_gap < 9'd320) step = (time_gap[2:0] == 3'b000);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = SCROLL;
      SCROLL:  if (time_gap >= GAP_MAX) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Episode end wins over a coincident trigger; the edge is consumed by at_ceil_q on the same tick.
  always_comb begin
    gap_nxt   = '0;
    hit_nxt   = 1'b0;
    start_nxt = 1'b0;
    dist_nxt  = (step && scroll_dist != 10'h3FF) ? scroll_dist + 10'd1 : scroll_dist;
    case (state)
      IDLE: begin
        if (trigger) begin
          gap_nxt   = 9'd1;
          hit_nxt   = 1'b1;
          start_nxt = 1'b1;
        end
      end
      SCROLL: begin
        if (time_gap >= GAP_MAX) begin
          gap_nxt = '0;
        end else if (trigger && retrig) begin
          gap_nxt   = 9'd1;
          hit_nxt   = 1'b1;
          start_nxt = 1'b1;
        end else begin
          gap_nxt = time_gap + 9'd1;
          hit_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state        <= IDLE;
      hit_ceiling  <= 1'b0;
      time_gap     <= '0;
      scroll_dist  <= '0;
      scroll_start <= 1'b0;
      at_ceil_q    <= 1'b0;
    end else if (update) begin
      state        <= state_nxt;
      hit_ceiling  <= hit_nxt;
      time_gap     <= gap_nxt;
      scroll_dist  <= dist_nxt;
      scroll_start <= start_nxt;
      at_ceil_q    <= at_ceil;
    end else begin
      scroll_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl: directed episodes plus random stimulus against a frame-level model.
module tb_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst, frame_tick, freeze, player_rising;
  logic [9:0] player_y;
  logic       hit_ceiling, scroll_start;
  logic [8:0] time_gap;
  logic [9:0] scroll_dist;

`ifdef SCROLL_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  scroll_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .freeze       (freeze),
    .player_y     (player_y),
    .player_rising(player_rising),
    .hit_ceiling  (hit_ceiling),
    .time_gap     (time_gap),
    .scroll_dist  (scroll_dist),
    .scroll_start (scroll_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts;

  // Reference model: an episode is "active" with frame index m_gap; distance is summed in plain integers.
  bit m_active, m_prev, m_start;
  int m_gap, m_dist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int step_of(input int g);
    if (g >= 1   && g < 80)  return 1;
    if (g >= 80  && g < 160) return (g % 2 == 0) ? 1 : 0;
    if (g >= 160 && g < 240) return (g % 4 == 0) ? 1 : 0;
    if (g >= 240 && g < 320) return (g % 8 == 0) ? 1 : 0;
    return 0;
  endfunction

  function automatic void model_edge(input bit r, input bit t, input bit f, input int y, input bit rise);
    bit at, trig;
    if (!r) begin
      m_active = 0; m_gap = 0; m_dist = 0; m_prev = 0; m_start = 0;
    end else if (t && !f) begin
      at   = (y <= 40) && rise;
      trig = at && !m_prev;
      m_start = 0;
      if (m_active) begin
        m_dist = m_dist + step_of(m_gap);
        if (m_dist > 1023) m_dist = 1023;
        if (m_gap == 320) begin
          m_active = 0; m_gap = 0;
        end else if (trig && RETRIG) begin
          m_gap = 1; m_start = 1;
        end else begin
          m_gap = m_gap + 1;
        end
      end else if (trig) begin
        m_active = 1; m_gap = 1; m_start = 1;
      end
      m_prev = at;
    end else begin
      m_start = 0;
    end
  endfunction

  task automatic clock(input bit r, input bit t, input bit f, input int y, input bit rise);
    rst = r; frame_tick = t; freeze = f; player_y = y[9:0]; player_rising = rise;
    @(posedge clk);
    model_edge(r, t, f, y, rise);
    #1;
    check("hit_ceiling", {31'd0, hit_ceiling}, {31'd0, m_active});
    check("time_gap", {23'd0, time_gap}, m_gap);
    check("scroll_dist", {22'd0, scroll_dist}, m_dist);
    check("scroll_start", {31'd0, scroll_start}, {31'd0, m_start});
    if (scroll_start) n_starts++;
  endtask

  // One frame: a tick clock followed by an idle clock where nothing may move.
  task automatic tick(input int y, input bit rise, input bit f = 1'b0);
    clock(1'b1, 1'b1, f, y, rise);
    clock(1'b1, 1'b0, f, y, rise);
  endtask

  task automatic do_reset();
    repeat (3) clock(1'b0, 1'b0, 1'b0, 200, 1'b0);
    n_starts = 0;
  endtask

  task automatic run_to_gap(input int target, input string tag);
    for (int i = 0; i < 400 && time_gap != target[8:0]; i++) tick(200, 1'b0);
    check(tag, {23'd0, time_gap}, target);
  endtask

  task automatic run_to_idle(input string tag);
    for (int i = 0; i < 400 && time_gap != 9'd0; i++) tick(200, 1'b0);
    check(tag, {23'd0, time_gap}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    // Reset and idle
    do_reset();
    check("rst_hit", {31'd0, hit_ceiling}, 0);
    check("rst_gap", {23'd0, time_gap}, 0);
    check("rst_dist", {22'd0, scroll_dist}, 0);
    check("rst_start", {31'd0, scroll_start}, 0);
    repeat (10) tick(200, 1'b0);
    check("idle_starts", n_starts, 0);
    check("idle_gap", {23'd0, time_gap}, 0);

    // Single episode: time_gap walks 1..320 then drops to idle
    tick(30, 1'b1);
    check("ep_first", {23'd0, time_gap}, 1);
    for (int k = 2; k <= 320; k++) begin
      tick(200, 1'b0);
      check("ep_seq", {23'd0, time_gap}, k);
    end
    tick(200, 1'b0);
    check("ep_end_hit", {31'd0, hit_ceiling}, 0);
    check("ep_end_gap", {23'd0, time_gap}, 0);
    check("ep_dist", {22'd0, scroll_dist}, 149);
    check("ep_starts", n_starts, 1);

    // Level hold: one episode only
    do_reset();
    repeat (400) tick(30, 1'b1);
    check("hold_starts", n_starts, 1);
    check("hold_dist", {22'd0, scroll_dist}, 149);
    check("hold_gap", {23'd0, time_gap}, 0);

    // Freeze mid-episode
    do_reset();
    tick(30, 1'b1);
    run_to_gap(100, "frz_reach");
    d = scroll_dist;
    repeat (50) tick(30, 1'b1, 1'b1);
    check("frz_gap", {23'd0, time_gap}, 100);
    check("frz_dist", {22'd0, scroll_dist}, d);
    tick(200, 1'b0);
    check("frz_resume", {23'd0, time_gap}, 101);

    // Reset mid-episode
    run_to_gap(200, "mid_reach");
    clock(1'b0, 1'b0, 1'b0, 200, 1'b0);
    check("mid_rst_hit", {31'd0, hit_ceiling}, 0);
    check("mid_rst_gap", {23'd0, time_gap}, 0);
    check("mid_rst_dist", {22'd0, scroll_dist}, 0);

    // Retrigger attempt after one frame with at_ceil low
    do_reset();
    tick(30, 1'b1);
    run_to_gap(49, "rt_reach");
    tick(30, 1'b1);
    check("rt_gap", {23'd0, time_gap}, RETRIG ? 1 : 50);
    check("rt_starts", n_starts, RETRIG ? 2 : 1);
    run_to_idle("rt_idle");
    check("rt_dist", {22'd0, scroll_dist}, RETRIG ? 198 : 149);

    // Saturation: eight episodes exceed 1023
    do_reset();
    for (int e = 0; e < 8; e++) begin
      tick(30, 1'b1);
      run_to_idle("sat_idle");
    end
    check("sat_dist", {22'd0, scroll_dist}, 1023);

    // Random stimulus against the model
    do_reset();
    repeat (6000)
      clock($urandom_range(0, 1999) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 80), $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
